// File: rtl/bsg_manycore_pkg.sv
// Shared manycore types: load-formatting info carried with remote loads,
// and the state encoding of the endpoint memory client.
package bsg_manycore_pkg;

    typedef struct packed {
        logic       float_wb;
        logic       icache_fetch;
        logic       is_unsigned_op;
        logic       is_byte_op;
        logic       is_hex_op;
        logic [1:0] part_sel;
    } bsg_manycore_load_info_s;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } ep_mem_client_state_e;

endpackage

// File: rtl/bsg_manycore_load_formatter.sv
// Combinational load formatter: byte/half select with sign or zero extension,
// full word otherwise. float_wb and icache_fetch do not alter the data.
module bsg_manycore_load_formatter
    import bsg_manycore_pkg::*;
(
    input  logic [31:0]             i_raw,
    input  bsg_manycore_load_info_s i_load_info,
    input  logic [1:0]              i_part_sel,
    output logic [31:0]             o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sext;
    logic        w_unused_info;

    assign w_byte = i_raw[8*i_part_sel +: 8];
    assign w_half = i_raw[16*i_part_sel[1] +: 16];
    assign w_sext = ~i_load_info.is_unsigned_op;

    // part_sel arrives on its own port, so the copy inside load_info is spare.
    assign w_unused_info = ^{i_load_info.float_wb, i_load_info.icache_fetch,
                             i_load_info.part_sel};

    // NOTE: every path assigns o_data from a default first, so no latch is inferred.
    always_comb begin
        o_data = i_raw;
        if (i_load_info.is_byte_op)
            o_data = {{24{w_sext & w_byte[7]}}, w_byte};
        else if (i_load_info.is_hex_op)
            o_data = {{16{w_sext & w_half[15]}}, w_half};
    end

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous SRAM with per-byte write mask; read data appears
// one cycle after the access and holds until the next read.
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter int els_p        = 1024,
    parameter int data_width_p = 32,
    parameter int addr_width_p = $clog2(els_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      v_i,
    input  logic                      w_i,
    input  logic [addr_width_p-1:0]   addr_i,
    input  logic [data_width_p-1:0]   data_i,
    input  logic [data_width_p/8-1:0] write_mask_i,
    output logic [data_width_p-1:0]   data_o
);
    logic [data_width_p-1:0] r_mem [els_p];
    logic [data_width_p-1:0] r_data;
    logic                    w_unused_reset;

    assign w_unused_reset = reset_i;

    // NOTE: the array has no reset; clearing it would forbid mapping onto a real SRAM macro.
    always_ff @(posedge clk_i) begin
        if (v_i & w_i) begin
            for (int i = 0; i < data_width_p/8; i++)
                if (write_mask_i[i]) r_mem[addr_i][8*i +: 8] <= data_i[8*i +: 8];
        end
        if (v_i & ~w_i) r_data <= r_mem[addr_i];
    end

    assign data_o = r_data;

endmodule

// File: rtl/bsg_manycore_ep_mem_client.sv
// Endpoint memory client: serves one remote load/store at a time from a local
// byte-masked SRAM, with optional wait states before the response pulse.
module bsg_manycore_ep_mem_client
    import bsg_manycore_pkg::*;
#(
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 16,
    parameter int mem_els_p      = 1024,
    parameter int wait_cycles_p  = 0,
    parameter int x_cord_width_p = 7,
    parameter int y_cord_width_p = 7
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        in_v_i,
    input  logic [data_width_p-1:0]     in_data_i,
    input  logic [data_width_p/8-1:0]   in_mask_i,
    input  logic [addr_width_p-1:0]     in_addr_i,
    input  logic                        in_we_i,
    input  bsg_manycore_load_info_s     in_load_info_i,
    input  logic [x_cord_width_p-1:0]   in_src_x_cord_i,
    input  logic [y_cord_width_p-1:0]   in_src_y_cord_i,
    output logic                        in_yumi_o,
    output logic [data_width_p-1:0]     returning_data_o,
    output logic                        returning_v_o,
    output logic [15:0]                 oob_count_o
);
    localparam int                    lp_lg_els = $clog2(mem_els_p);
    localparam logic [addr_width_p:0] lp_els    = (addr_width_p+1)'(mem_els_p);
    localparam logic [3:0]            lp_wait   = 4'(wait_cycles_p);

    ep_mem_client_state_e    r_state, w_next;
    logic [3:0]              r_cnt;
    logic                    r_we, r_oob;
    bsg_manycore_load_info_s r_load_info;
    logic [1:0]              r_part_sel;
    logic [data_width_p-1:0] r_hold, w_sram_data, w_raw, w_fmt;
    logic [15:0]             r_oob_count;
    logic                    w_oob, w_unused_cords;

    assign w_oob          = {1'b0, in_addr_i} >= lp_els;
    assign w_unused_cords = ^{in_src_x_cord_i, in_src_y_cord_i};

    always_comb begin
        w_next        = r_state;
        in_yumi_o     = 1'b0;
        returning_v_o = 1'b0;
        case (r_state)
            IDLE: begin
                in_yumi_o = in_v_i & ~reset_i;
                if (in_yumi_o) w_next = (lp_wait == 4'd0) ? RESP : WAIT;
            end
            WAIT:    if (r_cnt == 4'd1) w_next = RESP;
            RESP: begin
                returning_v_o = 1'b1;
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // NOTE: state is registered with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_oob_count <= 16'd0;
        end else begin
            r_state <= w_next;
            if (in_yumi_o)            r_cnt <= lp_wait;
            else if (r_state == WAIT) r_cnt <= r_cnt - 4'd1;
            if (in_yumi_o && w_oob && r_oob_count != 16'hFFFF)
                r_oob_count <= r_oob_count + 16'd1;
        end
    end

    // Request attributes and the held read word are only consumed after
    // acceptance, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (in_yumi_o) begin
            r_we        <= in_we_i;
            r_oob       <= w_oob;
            r_load_info <= in_load_info_i;
            r_part_sel  <= in_load_info_i.part_sel;
        end
        if (r_state == WAIT && r_cnt == lp_wait) r_hold <= w_sram_data;
    end

    bsg_mem_1rw_sync_mask_write_byte #(
        .els_p        (mem_els_p),
        .data_width_p (data_width_p),
        .addr_width_p (lp_lg_els)
    ) u_sram (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .v_i          (in_yumi_o),
        .w_i          (in_we_i & ~w_oob),
        .addr_i       (in_addr_i[lp_lg_els-1:0]),
        .data_i       (in_data_i),
        .write_mask_i (in_mask_i),
        .data_o       (w_sram_data)
    );

    assign w_raw = (lp_wait == 4'd0) ? w_sram_data : r_hold;

    bsg_manycore_load_formatter u_fmt (
        .i_raw       (w_raw),
        .i_load_info (r_load_info),
        .i_part_sel  (r_part_sel),
        .o_data      (w_fmt)
    );

    assign returning_data_o = (returning_v_o && !r_we && !r_oob) ? w_fmt : '0;
    assign oob_count_o      = r_oob_count;

    a_v_known: assert property (@(posedge clk_i) disable iff (reset_i) !$isunknown(in_v_i))
        else $error("in_v_i is unknown");
    a_mask_nonzero: assert property (@(posedge clk_i) disable iff (reset_i)
        !(in_yumi_o && in_we_i && in_mask_i == '0))
        else $warning("store accepted with empty byte mask");

endmodule

// File: tb/tb_bsg_manycore_ep_mem_client.sv
// Directed bench: one client with no wait states, one with three, sharing
// request fields but with separate valids.
module tb_bsg_manycore_ep_mem_client;
    import bsg_manycore_pkg::*;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                    reset_i, v0, v3, we;
    logic [31:0]             data;
    logic [3:0]              mask;
    logic [15:0]             addr;
    bsg_manycore_load_info_s info;
    logic                    yumi0, rv0, yumi3, rv3;
    logic [31:0]             rdata0, rdata3;
    logic [15:0]             oob0, oob3;

    int n_tests = 0;
    int n_fail  = 0;

    bsg_manycore_ep_mem_client #(.wait_cycles_p(0)) dut0 (
        .clk_i(clk_i), .reset_i(reset_i), .in_v_i(v0), .in_data_i(data),
        .in_mask_i(mask), .in_addr_i(addr), .in_we_i(we), .in_load_info_i(info),
        .in_src_x_cord_i(7'd0), .in_src_y_cord_i(7'd0), .in_yumi_o(yumi0),
        .returning_data_o(rdata0), .returning_v_o(rv0), .oob_count_o(oob0)
    );

    bsg_manycore_ep_mem_client #(.wait_cycles_p(3)) dut3 (
        .clk_i(clk_i), .reset_i(reset_i), .in_v_i(v3), .in_data_i(data),
        .in_mask_i(mask), .in_addr_i(addr), .in_we_i(we), .in_load_info_i(info),
        .in_src_x_cord_i(7'd1), .in_src_y_cord_i(7'd1), .in_yumi_o(yumi3),
        .returning_data_o(rdata3), .returning_v_o(rv3), .oob_count_o(oob3)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic bsg_manycore_load_info_s mk(input logic b, input logic h,
                                                    input logic u, input logic [1:0] p);
        bsg_manycore_load_info_s li;
        li = '0;
        li.is_byte_op     = b;
        li.is_hex_op      = h;
        li.is_unsigned_op = u;
        li.part_sel       = p;
        return li;
    endfunction

    // One full transaction on the zero-wait client: yumi in cycle N, response in N+1.
    task automatic req0(input string tag, input logic w, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        input bsg_manycore_load_info_s li, input logic [31:0] exp);
        @(negedge clk_i);
        we = w; addr = a; data = d; mask = m; info = li; v0 = 1'b1;
        #1 check({tag, "_yumi"}, {31'd0, yumi0}, 32'd1);
        @(posedge clk_i);
        #1 v0 = 1'b0;
        check({tag, "_rv"}, {31'd0, rv0}, 32'd1);
        check({tag, "_data"}, rdata0, exp);
        @(posedge clk_i);
        #1 check({tag, "_rv_drop"}, {31'd0, rv0}, 32'd0);
    endtask

    initial begin
        reset_i = 1'b1; v0 = 1'b0; v3 = 1'b0; we = 1'b0;
        data = '0; mask = '0; addr = '0; info = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        check("rst_yumi0", {31'd0, yumi0}, 32'd0);
        check("rst_rv0",   {31'd0, rv0},   32'd0);
        check("rst_data0", rdata0,         32'd0);
        check("rst_oob0",  {16'd0, oob0},  32'd0);
        check("rst_rv3",   {31'd0, rv3},   32'd0);
        check("rst_oob3",  {16'd0, oob3},  32'd0);

        req0("st_word", 1'b1, 16'd5, 32'hDEADBEEF, 4'hF, mk(0, 0, 0, 0), 32'h0);
        req0("ld_word", 1'b0, 16'd5, 32'h0,        4'hF, mk(0, 0, 0, 0), 32'hDEADBEEF);

        req0("st_pat",   1'b1, 16'd5, 32'h80FF7F01, 4'hF, mk(0, 0, 0, 0), 32'h0);
        req0("ld_b3s",   1'b0, 16'd5, 32'h0, 4'hF, mk(1, 0, 0, 2'd3), 32'hFFFFFF80);
        req0("ld_b3u",   1'b0, 16'd5, 32'h0, 4'hF, mk(1, 0, 1, 2'd3), 32'h00000080);
        req0("ld_h2s",   1'b0, 16'd5, 32'h0, 4'hF, mk(0, 1, 0, 2'd2), 32'hFFFF80FF);
        req0("ld_b1s",   1'b0, 16'd5, 32'h0, 4'hF, mk(1, 0, 0, 2'd1), 32'h0000007F);
        req0("ld_b0u",   1'b0, 16'd5, 32'h0, 4'hF, mk(1, 0, 1, 2'd0), 32'h00000001);
        req0("ld_h0u",   1'b0, 16'd5, 32'h0, 4'hF, mk(0, 1, 1, 2'd0), 32'h00007F01);

        req0("st_base",  1'b1, 16'd6, 32'hAABBCCDD, 4'hF,    mk(0, 0, 0, 0), 32'h0);
        req0("st_mask",  1'b1, 16'd6, 32'h11223344, 4'b0101, mk(0, 0, 0, 0), 32'h0);
        req0("ld_mask",  1'b0, 16'd6, 32'h0,        4'hF,    mk(0, 0, 0, 0), 32'hAA22CC44);

        req0("st_top",   1'b1, 16'd1023, 32'h0A0B0C0D, 4'hF, mk(0, 0, 0, 0), 32'h0);
        req0("ld_top",   1'b0, 16'd1023, 32'h0,        4'hF, mk(0, 0, 0, 0), 32'h0A0B0C0D);
        check("oob_inrange", {16'd0, oob0}, 32'd0);
        req0("st_w0",    1'b1, 16'd0,    32'h12345678, 4'hF, mk(0, 0, 0, 0), 32'h0);
        req0("ld_oob",   1'b0, 16'd1024, 32'h0,        4'hF, mk(0, 0, 0, 0), 32'h0);
        check("oob_cnt1", {16'd0, oob0}, 32'd1);
        req0("st_oob",   1'b1, 16'd1024, 32'hFFFFFFFF, 4'hF, mk(0, 0, 0, 0), 32'h0);
        check("oob_cnt2", {16'd0, oob0}, 32'd2);
        req0("ld_w0",    1'b0, 16'd0,    32'h0,        4'hF, mk(0, 0, 0, 0), 32'h12345678);

        // Three wait states with valid held high: yumi every 5 cycles,
        // response 4 cycles after each acceptance.
        @(negedge clk_i);
        we = 1'b1; addr = 16'd7; data = 32'hCAFEF00D; mask = 4'hF; info = mk(0, 0, 0, 0);
        v3 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk_i);
            if (k == 5) we = 1'b0;
            #1;
            check($sformatf("w3_yumi_c%0d", k), {31'd0, yumi3}, (k % 5 == 0) ? 32'd1 : 32'd0);
            check($sformatf("w3_rv_c%0d", k),   {31'd0, rv3},   (k % 5 == 4) ? 32'd1 : 32'd0);
            if (k == 4) check("w3_st_data", rdata3, 32'h0);
            if (k == 9) check("w3_ld_data", rdata3, 32'hCAFEF00D);
        end
        v3 = 1'b0;
        repeat (6) @(posedge clk_i);

        // Reset while the wait-state client sits in WAIT: the response is dropped.
        @(negedge clk_i);
        we = 1'b0; addr = 16'd7; v3 = 1'b1;
        #1 check("rst_mid_yumi", {31'd0, yumi3}, 32'd1);
        @(negedge clk_i);
        v3 = 1'b0; reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        #1 check("rst_mid_oob0", {16'd0, oob0}, 32'd0);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("rst_mid_norv%0d", j), {31'd0, rv3}, 32'd0);
            @(negedge clk_i);
            #1;
        end
        v3 = 1'b1;
        #1 check("rst_resume_yumi", {31'd0, yumi3}, 32'd1);
        @(negedge clk_i);
        v3 = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            #1;
            check($sformatf("rst_resume_rv%0d", j), {31'd0, rv3}, (j == 4) ? 32'd1 : 32'd0);
            if (j == 4) check("rst_resume_data", rdata3, 32'hCAFEF00D);
            @(negedge clk_i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
